// File: rtl/mem_stream_pkg.sv
// Shared types for the memory region streamer: FSM states, FIFO entry, default depth.
// ADDR_SIZE / DATA_SIZE fall back to 23 / 32 when the surrounding build does not define them.
`ifndef ADDR_SIZE
`define ADDR_SIZE 23
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package mem_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [`DATA_SIZE-1:0] data;
        logic                  last;
    } fifo_entry_t;

    localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/mem_stream_fifo.sv
// Synchronous FIFO of entry structs; write visible at head one cycle after push.
// Push when full and pop when empty are dropped; push+pop together leave the count unchanged.
module mem_stream_fifo
    import mem_stream_pkg::*;
#(
    parameter int  DEPTH   = FIFO_DEPTH_DEF,
    parameter type entry_t = fifo_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  entry_t                   i_push_dat,
    input  logic                     i_pop,
    output entry_t                   o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head reads as zero when empty so the storage itself needs no reset.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_region_streamer.sv
// Walks a word region through a memory handle, one outstanding read, words out on valid/ready; start->r_en 2 edges.
// Reads stall while the output FIFO is full; MEM_STREAM_BOUNDS_CHECK_EN rejects reversed regions with an err pulse.
module mem_region_streamer
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W     = `ADDR_SIZE,
    parameter int DATA_W     = `DATA_SIZE,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] region_begin,
    input  logic [ADDR_W-1:0] region_end,
    output logic [ADDR_W-1:0] mh_region_begin,
    output logic [ADDR_W-1:0] mh_region_end,
    output logic [ADDR_W-1:0] mh_ptr,
    output logic              mh_r_en,
    output logic              mh_w_en,
    output logic              mh_write_through,
    output logic              mh_read_through,
    input  logic              mh_avail,
    input  logic              mh_done,
    input  logic [DATA_W-1:0] mh_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } entry_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_begin;
    logic [ADDR_W-1:0] r_end;
    logic [ADDR_W:0]   r_remaining;
    logic              r_r_en;
    logic              r_err;
    logic              w_reject;
    logic              w_start_ok;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_last_word;
    logic [CW:0]       w_count;
    logic [ADDR_W-1:0] w_span;
    entry_t            w_push_dat;
    entry_t            w_head;

`ifdef MEM_STREAM_BOUNDS_CHECK_EN
    assign w_reject = (region_end < region_begin);
`else
    assign w_reject = 1'b0;
`endif

    assign w_start_ok  = (r_state == ST_IDLE) && start && !w_reject;
    assign w_issue     = (r_state == ST_REQ) && mh_avail && !w_full;
    assign w_push      = (r_state == ST_WAIT) && mh_done;
    assign w_pop       = !w_empty && out_ready;
    assign w_last_word = (r_remaining == (ADDR_W+1)'(1));
    assign w_span      = region_end - region_begin + 1'b1;

    assign w_push_dat.data = mh_data;
    assign w_push_dat.last = w_last_word;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_nxt = ST_REQ;
            ST_REQ:   if (w_issue) w_state_nxt = ST_WAIT;
            ST_WAIT:  if (mh_done) w_state_nxt = w_last_word ? ST_DRAIN : ST_REQ;
            ST_DRAIN: if (w_empty || (w_pop && w_count == (CW+1)'(1))) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_begin     <= '0;
            r_end       <= '0;
            r_remaining <= '0;
            r_r_en      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_reject) begin
                        r_err <= 1'b1;
                    end else if (start) begin
                        r_begin     <= region_begin;
                        r_end       <= region_end;
                        r_ptr       <= region_begin;
                        // A span of zero in the low bits means the full 2^ADDR_W words.
                        r_remaining <= {(w_span == '0), w_span};
                    end
                end
                ST_REQ: begin
                    if (w_issue) begin
                        r_r_en <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mh_done) begin
                        r_r_en      <= 1'b0;
                        r_ptr       <= r_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_stream_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign mh_region_begin  = r_begin;
    assign mh_region_end    = r_end;
    assign mh_ptr           = r_ptr;
    assign mh_r_en          = r_r_en;
    assign mh_w_en          = 1'b0;
    assign mh_write_through = 1'b0;
    assign mh_read_through  = 1'b0;
    assign out_data         = w_head.data;
    assign out_last         = w_head.last;
    assign out_valid        = !w_empty;
    assign busy             = (r_state != ST_IDLE);
    assign err              = r_err;

endmodule

// File: doc/mem_region_streamer.md
# mem_region_streamer

Read-side client of a memory handle. On `start`, walks `ptr` from `region_begin` to `region_end` inclusive, issuing one single-word read per address through the handle's request/`done` protocol. Buffers the returned words in a small FIFO and presents them as a valid/ready stream with a `last` marker. Sits between the memory arbiter, which services handles, and the compute units that consume tensor operands.

## Interface

Parameters:
- `ADDR_W`, default 23 (`ADDR_SIZE`): address width.
- `DATA_W`, default 32 (`DATA_SIZE`): data width.
- `FIFO_DEPTH`, default 4: output buffer entries; power of two, minimum 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `region_begin`  in  ADDR_W  first word address; sampled on accepted `start`.
- `region_end`  in  ADDR_W  last word address, inclusive; sampled on accepted `start`.
- `mh_region_begin`, `mh_region_end`  out  ADDR_W  registered copies of the sampled bounds, driven to the handle.
- `mh_ptr`  out  ADDR_W  current read address.
- `mh_r_en`  out  1  read request.
- `mh_w_en`, `mh_write_through`, `mh_read_through`  out  1  tied 0.
- `mh_avail`  in  1  arbiter can accept a request.
- `mh_done`  in  1  one-cycle pulse: `mh_data` is valid for the current `mh_ptr`.
- `mh_data`  in  DATA_W  read data.
- `out_data`  out  DATA_W  stream data.
- `out_valid`  out  1  stream valid.
- `out_last`  out  1  qualifies the final word of the region.
- `out_ready`  in  1  consumer accepts.
- `busy`  out  1  high from accepted `start` until the final word leaves the FIFO.
- `err`  out  1  one-cycle pulse on a rejected region (macro-dependent).

## Operation

State machine:
- **IDLE**
  - Accepted `start` samples the bounds, sets `mh_ptr`=`region_begin` and `remaining`=`region_end`-`region_begin`+1 (ADDR_W+1 bits, modulo 2^ADDR_W in the low bits).
  - Goes to REQ.
- **REQ**
  - Asserts `mh_r_en` only when `mh_avail`=1 and the FIFO has at least one free slot.
  - Once asserted, `mh_r_en` and `mh_ptr` are held stable until `mh_done`. Go to WAIT.
- **WAIT**
  - On `mh_done`: `mh_data` is pushed into the FIFO, tagged `last` when `remaining`=1.
  - `mh_r_en` drops on the same edge; `mh_ptr` increments, wrapping modulo 2^ADDR_W; `remaining` decrements.
  - If `remaining` becomes 0, go to DRAIN; otherwise go to REQ.
- **DRAIN**
  - Waits for the FIFO to empty, then returns to IDLE and deasserts `busy`.

Rules:
- `start` outside IDLE is ignored.
- At most one read is outstanding at any time.
- `mh_done` outside WAIT is ignored.
- FIFO push and pop in the same cycle are both honoured, and the count is unchanged.
- FIFO full: REQ holds off; no read is ever issued without a free slot.
- `out_data`, `out_valid` and `out_last` come straight from the FIFO head.
  - They must remain stable while `out_valid`=1 and `out_ready`=0.

## Timing

Reset values, asserted immediately and asynchronously:
- State is IDLE; FIFO is empty.
- `mh_r_en`=0, `mh_ptr`=0, `mh_region_begin`=0, `mh_region_end`=0.
- `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `err`=0.

Reset mid-transfer:
- Discards in-flight data and FIFO contents.
- A later `mh_done` is ignored.

Latency and throughput:
- `start` at edge N puts `mh_r_en` high after edge N+1, provided `mh_avail`=1.
- A word returned by `mh_done` at edge M appears on `out_valid` after edge M (registered FIFO write; the head is visible the next cycle).
- Peak rate is one word per 2 cycles when `mh_done` follows one cycle after `mh_r_en`.
  - This comes from the one-cycle REQ gap after each `done`.

## Configuration

`MEM_STREAM_BOUNDS_CHECK_EN`:
- **Defined:** `start` with `region_end` < `region_begin`:
  - pulses `err` for one cycle;
  - issues no reads;
  - stays in IDLE;
  - leaves `busy`=0.
- **Undefined:** `err` is tied 0. A reversed region wraps through 2^ADDR_W and streams `region_end`-`region_begin`+1 modulo 2^ADDR_W words.
- In both builds, `region_begin`=`region_end` streams exactly 1 word.

## Structure

- Shared package `mem_stream_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, DRAIN);
  - the FIFO entry typedef (`data`, `last`);
  - the default `FIFO_DEPTH`.
- Widths use the existing `ADDR_SIZE` and `DATA_SIZE` defines.
- One sub-module, `mem_stream_fifo`:
  - synchronous FIFO of entry structs;
  - ports: push, pop, full, empty, count;
  - async active-high reset.

## Test plan

- **Basic stream:** begin=0x10, end=0x13; memory returns data = addr+0x100, with `done` 1 cycle after `r_en`. Expect 4 words 0x110..0x113, `last` only on 0x113, `busy` low after the final handshake.
- **Backpressure:** depth 4, region of 8 words, `out_ready`=0 for 20 cycles. Expect exactly 4 reads issued, then `r_en` stays low. Releasing `out_ready` yields all 8 words in order.
- **Arbiter stall:** `mh_avail`=0 for 10 cycles after `start`. Expect `r_en` to stay 0. Then hold `done` off for 5 cycles after `r_en`; `ptr` must remain stable throughout.
- **Single word / wrap:** begin=end=0x7FFFFF gives 1 word with `last`. Begin=0x7FFFFE, end=0x000001 without the macro gives 4 words and `ptr` wrapping to 0.
- **Bounds check:** with `MEM_STREAM_BOUNDS_CHECK_EN`, begin=0x20, end=0x1F gives a 1-cycle `err` pulse, no `r_en`, and `busy`=0.
- **Reset mid-op:** assert `rst` while in WAIT with 2 words buffered. Expect `r_en`, `out_valid` and `busy` to drop immediately. A stale `done` after reset must produce no output.
